button_conditioner: RTL and testbench

//  Front-end stage for the panel push-buttons: takes raw async active-low buttons and drives the control inputs of the downstream counter.
//  Per channel: 2-FF synchronises, debounces, and emits a clean pressed level, press/release pulses and a hold auto-repeat tick.

---
 rtl/button_conditioner.sv | 170 +++++++++++++++++
 tb/tb_button_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Purpose: per-channel 2-FF sync, debounce, press/release pulses and hold auto-repeat for panel buttons.
// Latency: Q/P rise 2+DB_CYCLES edges after a pin falls; L falls-edge likewise; all outputs registered.
// Backpressure: none; Q is a level, P/L/T are single-cycle strobes the consumer must take every cycle.
module button_conditioner #(
    parameter int N          = 2,
    parameter int DB_CYCLES  = 1000000,
    parameter int RPT_FIRST  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic         C,
    input  logic         R,
    input  logic [N-1:0] nB,
    output logic [N-1:0] Q,
    output logic [N-1:0] P,
    output logic [N-1:0] L,
    output logic [N-1:0] T
);

    // Debounce counter counts accepted-level-disagreeing samples, including the current one,
    // so the level flips on the edge where the DB_CYCLES-th consecutive sample is taken.
    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int RPT_MAX = (RPT_FIRST > RPT_PERIOD) ? RPT_FIRST : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE       = DB_W'(1);
    localparam logic [RPT_W-1:0] RPT_FIRST_V  = RPT_W'(RPT_FIRST);
    localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(RPT_PERIOD);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    for (genvar ch = 0; ch < N; ch++) begin : gCh
        logic             sync1;
        logic             sync2;
        logic             s;
        state_t           state;
        logic [DB_W-1:0]  dbCnt;
        logic [RPT_W-1:0] rptCnt;
        logic [RPT_W-1:0] rptNext;
        logic [RPT_W-1:0] rptTarget;
        logic             rptPeriodic;
        logic             q;
        logic             p;
        logic             l;
        logic             t;

        // Two-flop synchroniser; resets to the released (high) pin level
        always_ff @(posedge C) begin
            if (R) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= nB[ch];
                sync2 <= sync1;
            end
        end

        assign s         = ~sync2;
        assign rptNext   = rptCnt + RPT_W'(1);
        // First tick waits RPT_FIRST held cycles, later ticks RPT_PERIOD cycles
        assign rptTarget = rptPeriodic ? RPT_PERIOD_V : RPT_FIRST_V;

        // Debounce FSM with registered level, pulse and repeat outputs
        always_ff @(posedge C) begin
            if (R) begin
                state       <= IDLE;
                dbCnt       <= '0;
                rptCnt      <= '0;
                rptPeriodic <= 1'b0;
                q           <= 1'b0;
                p           <= 1'b0;
                l           <= 1'b0;
                t           <= 1'b0;
            end else begin
                p <= 1'b0;
                l <= 1'b0;
                t <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            if (DB_CYCLES == 1) begin
                                state       <= HELD;
                                dbCnt       <= '0;
                                rptCnt      <= '0;
                                rptPeriodic <= 1'b0;
                                q           <= 1'b1;
                                p           <= 1'b1;
                            end else begin
                                state <= PRESS_DB;
                                dbCnt <= DB_ONE;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (!s) begin
                            // Bounce: go back and start counting from scratch
                            state <= IDLE;
                            dbCnt <= '0;
                        end else if (dbCnt == DB_LAST) begin
                            state       <= HELD;
                            dbCnt       <= '0;
                            rptCnt      <= '0;
                            rptPeriodic <= 1'b0;
                            q           <= 1'b1;
                            p           <= 1'b1;
                        end else begin
                            dbCnt <= dbCnt + DB_ONE;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            if (DB_CYCLES == 1) begin
                                state       <= IDLE;
                                dbCnt       <= '0;
                                rptCnt      <= '0;
                                rptPeriodic <= 1'b0;
                                q           <= 1'b0;
                                l           <= 1'b1;
                            end else begin
                                state <= RELEASE_DB;
                                dbCnt <= DB_ONE;
                            end
                        end else if (RPT_FIRST != 0) begin
                            // Repeat counter reloads on each tick so it never wraps
                            if (rptNext == rptTarget) begin
                                t           <= 1'b1;
                                rptCnt      <= '0;
                                rptPeriodic <= 1'b1;
                            end else begin
                                rptCnt <= rptNext;
                            end
                        end
                    end
                    RELEASE_DB: begin
                        if (s) begin
                            // Release glitch: stay pressed, keep repeat phase where it was
                            state <= HELD;
                            dbCnt <= '0;
                        end else if (dbCnt == DB_LAST) begin
                            state       <= IDLE;
                            dbCnt       <= '0;
                            rptCnt      <= '0;
                            rptPeriodic <= 1'b0;
                            q           <= 1'b0;
                            l           <= 1'b1;
                        end else begin
                            dbCnt <= dbCnt + DB_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        dbCnt <= '0;
                        q     <= 1'b0;
                    end
                endcase
            end
        end

        assign Q[ch] = q;
        assign P[ch] = p;
        assign L[ch] = l;
        assign T[ch] = t;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose: bench for button_conditioner; two instances (repeat on / repeat disabled) share stimulus.
// Latency: outputs compared each negedge against a sample-history model, plus directed literal checks.
// Backpressure: none.
module tb_button_conditioner;
    localparam int DB = 4;
    localparam int RF = 10;
    localparam int RP = 3;

    logic       C  = 1'b0;
    logic       R  = 1'b1;
    logic [1:0] nB = 2'b11;
    logic [1:0] qA, pA, lA, tA;
    logic [1:0] qB, pB, lB, tB;

    button_conditioner #(.N(2), .DB_CYCLES(DB), .RPT_FIRST(RF), .RPT_PERIOD(RP)) dutA (
        .C(C), .R(R), .nB(nB), .Q(qA), .P(pA), .L(lA), .T(tA)
    );
    button_conditioner #(.N(2), .DB_CYCLES(DB), .RPT_FIRST(0), .RPT_PERIOD(RP)) dutB (
        .C(C), .R(R), .nB(nB), .Q(qB), .P(pB), .L(lB), .T(tB)
    );

    always #5 C = ~C;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accepted level, run length of disagreeing samples, held-cycle count.
    // Instance 0 has repeat enabled, instance 1 has it disabled.
    logic [1:0] mSync1 = 2'b11;
    logic [1:0] mSync2 = 2'b11;
    int         acc  [2][2];
    int         run  [2][2];
    int         held [2][2];
    logic [1:0] mQ [2];
    logic [1:0] mP [2];
    logic [1:0] mL [2];
    logic [1:0] mT [2];
    bit         started = 0;

    always @(posedge C) begin
        logic [1:0] smp;
        int         rf;
        if (R) begin
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 2; c++) begin
                    acc[i][c] = 0; run[i][c] = 0; held[i][c] = 0;
                end
                mQ[i] = 2'b00; mP[i] = 2'b00; mL[i] = 2'b00; mT[i] = 2'b00;
            end
            mSync1  = 2'b11;
            mSync2  = 2'b11;
            started = 1;
        end else begin
            smp = ~mSync2;
            for (int i = 0; i < 2; i++) begin
                rf = (i == 0) ? RF : 0;
                for (int c = 0; c < 2; c++) begin
                    mP[i][c] = 1'b0; mL[i][c] = 1'b0; mT[i][c] = 1'b0;
                    // Steady pressed with no pending change: count held cycles
                    if (acc[i][c] == 1 && run[i][c] == 0 && smp[c] && rf != 0) begin
                        held[i][c]++;
                        if (held[i][c] == rf || (held[i][c] > rf && (held[i][c] - rf) % RP == 0))
                            mT[i][c] = 1'b1;
                    end
                    if (int'(smp[c]) != acc[i][c]) begin
                        run[i][c]++;
                        if (run[i][c] == DB) begin
                            acc[i][c]  = int'(smp[c]);
                            run[i][c]  = 0;
                            held[i][c] = 0;
                            if (smp[c]) mP[i][c] = 1'b1;
                            else        mL[i][c] = 1'b1;
                        end
                    end else begin
                        run[i][c] = 0;
                    end
                    mQ[i][c] = (acc[i][c] == 1);
                end
            end
            mSync2 = mSync1;
            mSync1 = nB;
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge C) begin
        if (started) begin
            chk("cmp_Q_A", qA, mQ[0]);
            chk("cmp_P_A", pA, mP[0]);
            chk("cmp_L_A", lA, mL[0]);
            chk("cmp_T_A", tA, mT[0]);
            chk("cmp_Q_B", qB, mQ[1]);
            chk("cmp_P_B", pB, mP[1]);
            chk("cmp_L_B", lB, mL[1]);
            chk("cmp_T_B", tB, mT[1]);
            chk("cmp_PL_excl", pA & lA, 2'b00);
        end
    end

    int tBSeen = 0;
    always @(negedge C) if (tB != 2'b00) tBSeen++;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge C);
            #1;
        end
    endtask

    int p0At = -1;
    int p1At = -1;

    initial begin
        tick(3);
        chk("reset_Q", {qA, qB}, 4'h0);
        chk("reset_PLT", {pA, lA, tA, pB, lB, tB}, 12'h000);
        R = 1'b0;
        tick(2);

        // Clean press: Q/P on edge 6, T at P+10, P+13, ...
        nB[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("press_Q_early", qA[0], 1'b0);
        end
        tick(1);
        chk("press_Q_edge6", qA[0], 1'b1);
        chk("press_P_edge6", pA[0], 1'b1);
        for (int k = 7; k <= 40; k++) begin
            tick(1);
            chk("press_P_single", pA[0], 1'b0);
            chk("rpt_T_time", tA[0], (k >= 16 && (k - 16) % 3 == 0));
        end

        // Clean release: Q falls 6 edges later with one L
        nB[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("rel_Q_hold", qA[0], 1'b1);
            chk("rel_no_L", lA[0], 1'b0);
        end
        tick(1);
        chk("rel_Q_fall", qA[0], 1'b0);
        chk("rel_L", lA[0], 1'b1);
        tick(1);
        chk("rel_L_single", lA[0], 1'b0);

        // Bounce: 3 low, 1 high, 3 low -> rejected
        tick(4);
        nB[0] = 1'b0; tick(3);
        nB[0] = 1'b1; tick(1);
        nB[0] = 1'b0; tick(3);
        nB[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("bounce_Q", qA[0], 1'b0);
            chk("bounce_P", pA[0], 1'b0);
        end

        // Press again (fresh count) then release with a 2-cycle low glitch
        nB[0] = 1'b0;
        tick(5);
        chk("repress_Q_early", qA[0], 1'b0);
        tick(1);
        chk("repress_P_edge6", pA[0], 1'b1);
        tick(4);
        nB[0] = 1'b1; tick(3);
        nB[0] = 1'b0; tick(2);
        nB[0] = 1'b1;
        for (int k = 6; k <= 10; k++) begin
            tick(1);
            chk("glitch_Q_hold", qA[0], 1'b1);
        end
        tick(1);
        chk("glitch_L", lA[0], 1'b1);
        chk("glitch_Q_fall", qA[0], 1'b0);

        // Reset mid-hold: outputs clear, fresh P 6 edges after R drops, no L
        tick(3);
        nB[0] = 1'b0;
        tick(8);
        chk("mid_Q_held", qA[0], 1'b1);
        R = 1'b1;
        tick(1);
        chk("mid_reset_out", {qA, pA, lA, tA, qB, pB, lB, tB}, 16'h0000);
        R = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("mid_Q_low", qA[0], 1'b0);
            chk("mid_no_L", lA[0], 1'b0);
        end
        tick(1);
        chk("mid_P_again", pA[0], 1'b1);

        // Independence: channel 1 pressed 2 cycles after channel 0
        nB = 2'b11;
        tick(12);
        nB[0] = 1'b0;
        tick(2);
        nB[1] = 1'b0;
        for (int k = 3; k <= 12; k++) begin
            tick(1);
            if (pA[0]) p0At = k;
            if (pA[1]) p1At = k;
        end
        chk("indep_P0_at", p0At, 6);
        chk("indep_P1_at", p1At, 8);
        tick(30);
        nB = 2'b11;
        tick(10);
        chk("disable_T_never", tBSeen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
